// File: rtl/pa_fpu_wb_pkg.sv
// Shared constants and types for the FMAU writeback collector: special-result
// encodings, select-vector bit positions and the writeback buffer entry layout.
package pa_fpu_wb_pkg;

    localparam logic [31:0] QNAN_CANON  = 32'h7FC00000;
    localparam logic [30:0] MAXNORM_MAG = 31'h7F7FFFFF;

    localparam int SEL_QNAN      = 0;
    localparam int SEL_INF       = 1;
    localparam int SEL_ZERO      = 2;
    localparam int SEL_MAXNORM   = 3;
    localparam int SEL_SRC0      = 4;
    localparam int SEL_SRC1      = 5;
    localparam int SEL_SRC2      = 6;
    localparam int SEL_SRC0_QNAN = 7;

    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [4:0]  dst_reg;
        logic [31:0] data;
        logic [4:0]  fflags;
    } wb_entry_t;

endpackage

// File: rtl/pa_fpu_wb_fifo.sv
// Four-entry in-order writeback buffer: up to three pushes per cycle (slot 0
// is oldest and lands first), one pop per cycle, occupancy count exported.
module pa_fpu_wb_fifo
    import pa_fpu_wb_pkg::*;
(
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic [2:0]      push_vld_i,
    input  wb_entry_t [2:0] push_data_i,
    input  logic            pop_i,
    output wb_entry_t       head_o,
    output logic [2:0]      count_o
);

    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;
    wb_entry_t  mem_q [WB_DEPTH];

    logic [1:0] slot0, slot1, slot2;
    logic [1:0] push_num;
    logic       pop_en;
    logic [WB_DEPTH-1:0] wr_en;
    wb_entry_t [WB_DEPTH-1:0] wr_data;

    // Pushes are packed together: each lands after the ones older than it.
    always_comb begin
        slot0    = wr_ptr_q;
        slot1    = wr_ptr_q + {1'b0, push_vld_i[0]};
        slot2    = wr_ptr_q + {1'b0, push_vld_i[0]} + {1'b0, push_vld_i[1]};
        push_num = {1'b0, push_vld_i[0]} + {1'b0, push_vld_i[1]} + {1'b0, push_vld_i[2]};
        pop_en   = pop_i && (count_q != 3'd0);
        wr_ptr_d = wr_ptr_q + push_num;
        rd_ptr_d = rd_ptr_q + {1'b0, pop_en};
        count_d  = count_q + {1'b0, push_num} - {2'b00, pop_en};
    end

    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_entry
        assign wr_en[gi] = (push_vld_i[0] && (slot0 == 2'(gi)))
                        || (push_vld_i[1] && (slot1 == 2'(gi)))
                        || (push_vld_i[2] && (slot2 == 2'(gi)));
        assign wr_data[gi] = (push_vld_i[2] && (slot2 == 2'(gi))) ? push_data_i[2] :
                             (push_vld_i[1] && (slot1 == 2'(gi))) ? push_data_i[1] :
                                                                    push_data_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= wr_data[i];
                end
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pa_fmau_wb.sv
// FMAU writeback collector: tracks destination tags through EX2..EX4, builds
// the EX1 special result, queues completions in order and keeps sticky fflags.
module pa_fmau_wb
    import pa_fpu_wb_pkg::*;
(
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic [4:0]  idu_fpu_ex1_dst_reg,
    input  logic        ctrl_wb_ex1_pipe_down,
    input  logic        ctrl_wb_ex2_pipe_down,
    input  logic        ctrl_wb_ex3_pipe_down,
    input  logic        rtu_xx_ex1_cancel,
    input  logic        ctrl_xx_ex2_cancel,
    input  logic        ctrl_xx_ex4_stall,
    input  logic        fmau_fpu_ex1_cmplt,
    input  logic [7:0]  fmau_fpu_ex1_special_sel,
    input  logic [3:0]  fmau_fpu_ex1_special_sign,
    input  logic [4:0]  fmau_fpu_ex1_fflags,
    input  logic [31:0] idu_fpu_ex1_srcf0,
    input  logic [31:0] idu_fpu_ex1_srcf1,
    input  logic [31:0] dp_xx_ex1_srcf2,
    input  logic        fmau_fpu_ex3_result_vld,
    input  logic [31:0] fmau_fpu_ex3_result,
    input  logic [4:0]  fmau_fpu_ex3_fflags,
    input  logic [31:0] fmau_fpu_ex4_result,
    input  logic [4:0]  fmau_fpu_ex4_fflags,
    input  logic        rtu_fpu_wb_ready,
    input  logic        cp0_fpu_fflags_clr,
    output logic        fmau_wb_stall,
    output logic        fpu_rtu_wb_vld,
    output logic [4:0]  fpu_rtu_wb_reg,
    output logic [31:0] fpu_rtu_wb_data,
    output logic [4:0]  fpu_cp0_fflags
);

    logic       ex2_vld_q, ex2_vld_d, ex3_vld_q, ex3_vld_d, ex4_vld_q, ex4_vld_d;
    logic [4:0] ex2_tag_q, ex2_tag_d, ex3_tag_q, ex3_tag_d, ex4_tag_q, ex4_tag_d;
    logic [4:0] fflags_q, fflags_d;

    logic            ex4_push, ex3_push, ex1_push, wb_pop;
    logic [31:0]     special_cand [8];
    logic [31:0]     special_word;
    wb_entry_t [2:0] push_data;
    wb_entry_t       head;
    logic [2:0]      fifo_count;
    logic            sign3_unused;

    assign sign3_unused = fmau_fpu_ex1_special_sign[3];

    // Stall comes from the registered count only, so at most 1 + 3 pushes fit.
    assign fmau_wb_stall = (fifo_count >= 3'd2);
    assign ex4_push = ex4_vld_q && !ctrl_xx_ex4_stall && !fmau_wb_stall;
    assign ex3_push = fmau_fpu_ex3_result_vld && !fmau_wb_stall;
    assign ex1_push = fmau_fpu_ex1_cmplt && !rtu_xx_ex1_cancel && !fmau_wb_stall;

    always_comb begin
        ex2_vld_d = ex2_vld_q;
        ex2_tag_d = ex2_tag_q;
        ex3_vld_d = ex3_vld_q;
        ex3_tag_d = ex3_tag_q;
        ex4_vld_d = ex4_vld_q;
        ex4_tag_d = ex4_tag_q;
        if (ctrl_wb_ex1_pipe_down && !rtu_xx_ex1_cancel && !fmau_fpu_ex1_cmplt) begin
            ex2_vld_d = 1'b1;
            ex2_tag_d = idu_fpu_ex1_dst_reg;
        end else if (ctrl_wb_ex2_pipe_down) begin
            ex2_vld_d = 1'b0;
        end
        if (ctrl_wb_ex2_pipe_down && !ctrl_xx_ex2_cancel) begin
            ex3_vld_d = ex2_vld_q;
            ex3_tag_d = ex2_tag_q;
        end else if (ctrl_wb_ex3_pipe_down) begin
            ex3_vld_d = 1'b0;
        end
        if (ctrl_wb_ex3_pipe_down && !fmau_fpu_ex3_result_vld) begin
            ex4_vld_d = ex3_vld_q;
            ex4_tag_d = ex3_tag_q;
        end else if (ex4_push) begin
            ex4_vld_d = 1'b0;
        end
    end

    assign special_cand[SEL_QNAN]      = QNAN_CANON;
    assign special_cand[SEL_INF]       = {fmau_fpu_ex1_special_sign[0], 8'hFF, 23'h0};
    assign special_cand[SEL_ZERO]      = {fmau_fpu_ex1_special_sign[1], 31'h0};
    assign special_cand[SEL_MAXNORM]   = {fmau_fpu_ex1_special_sign[2], MAXNORM_MAG};
    assign special_cand[SEL_SRC0]      = idu_fpu_ex1_srcf0;
    assign special_cand[SEL_SRC1]      = idu_fpu_ex1_srcf1;
    assign special_cand[SEL_SRC2]      = dp_xx_ex1_srcf2;
    assign special_cand[SEL_SRC0_QNAN] = idu_fpu_ex1_srcf0 | 32'h0040_0000;

    // Scan from the top down so the lowest set select bit has the final word.
    always_comb begin
        special_word = '0;
        for (int i = 7; i >= 0; i--) begin
            if (fmau_fpu_ex1_special_sel[i]) begin
                special_word = special_cand[i];
            end
        end
    end

    assign push_data[0] = {ex4_tag_q, fmau_fpu_ex4_result, fmau_fpu_ex4_fflags};
    assign push_data[1] = {ex3_tag_q, fmau_fpu_ex3_result, fmau_fpu_ex3_fflags};
    assign push_data[2] = {idu_fpu_ex1_dst_reg, special_word, fmau_fpu_ex1_fflags};

    pa_fpu_wb_fifo u_fifo (
        .clk_i       (forever_cpuclk),
        .srst_i      (cpurst),
        .push_vld_i  ({ex1_push, ex3_push, ex4_push}),
        .push_data_i (push_data),
        .pop_i       (wb_pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign fpu_rtu_wb_vld  = (fifo_count != 3'd0);
    assign fpu_rtu_wb_reg  = head.dst_reg;
    assign fpu_rtu_wb_data = head.data;
    assign wb_pop          = fpu_rtu_wb_vld && rtu_fpu_wb_ready;

    // A clear in the same cycle as a pop keeps only the popped flags.
    always_comb begin
        fflags_d = fflags_q;
        if (wb_pop) begin
            fflags_d = cp0_fpu_fflags_clr ? head.fflags : (fflags_q | head.fflags);
        end else if (cp0_fpu_fflags_clr) begin
            fflags_d = '0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex2_vld_q <= 1'b0;
            ex3_vld_q <= 1'b0;
            ex4_vld_q <= 1'b0;
            ex2_tag_q <= '0;
            ex3_tag_q <= '0;
            ex4_tag_q <= '0;
            fflags_q  <= '0;
        end else begin
            ex2_vld_q <= ex2_vld_d;
            ex3_vld_q <= ex3_vld_d;
            ex4_vld_q <= ex4_vld_d;
            ex2_tag_q <= ex2_tag_d;
            ex3_tag_q <= ex3_tag_d;
            ex4_tag_q <= ex4_tag_d;
            fflags_q  <= fflags_d;
        end
    end

    assign fpu_cp0_fflags = fflags_q;

endmodule

// File: tb/tb_pa_fmau_wb.sv
// Scoreboard bench for pa_fmau_wb: the driver queues expected completions,
// a negedge monitor tracks occupancy/sticky flags and checks every pop.
module tb_pa_fmau_wb;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [4:0]  f;
    } exp_t;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic [4:0]  idu_fpu_ex1_dst_reg;
    logic        ctrl_wb_ex1_pipe_down, ctrl_wb_ex2_pipe_down, ctrl_wb_ex3_pipe_down;
    logic        rtu_xx_ex1_cancel, ctrl_xx_ex2_cancel, ctrl_xx_ex4_stall;
    logic        fmau_fpu_ex1_cmplt;
    logic [7:0]  fmau_fpu_ex1_special_sel;
    logic [3:0]  fmau_fpu_ex1_special_sign;
    logic [4:0]  fmau_fpu_ex1_fflags;
    logic [31:0] idu_fpu_ex1_srcf0, idu_fpu_ex1_srcf1, dp_xx_ex1_srcf2;
    logic        fmau_fpu_ex3_result_vld;
    logic [31:0] fmau_fpu_ex3_result;
    logic [4:0]  fmau_fpu_ex3_fflags;
    logic [31:0] fmau_fpu_ex4_result;
    logic [4:0]  fmau_fpu_ex4_fflags;
    logic        rtu_fpu_wb_ready;
    logic        cp0_fpu_fflags_clr;
    logic        fmau_wb_stall, fpu_rtu_wb_vld;
    logic [4:0]  fpu_rtu_wb_reg;
    logic [31:0] fpu_rtu_wb_data;
    logic [4:0]  fpu_cp0_fflags;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   cnt_m = 0;
    logic [4:0] sticky_m = '0;
    int   n_push_now = 0;
    int   ready_mode = 0;
    bit   rand_clr = 1'b0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    pa_fmau_wb dut (
        .forever_cpuclk            (forever_cpuclk),
        .cpurst                    (cpurst),
        .idu_fpu_ex1_dst_reg       (idu_fpu_ex1_dst_reg),
        .ctrl_wb_ex1_pipe_down     (ctrl_wb_ex1_pipe_down),
        .ctrl_wb_ex2_pipe_down     (ctrl_wb_ex2_pipe_down),
        .ctrl_wb_ex3_pipe_down     (ctrl_wb_ex3_pipe_down),
        .rtu_xx_ex1_cancel         (rtu_xx_ex1_cancel),
        .ctrl_xx_ex2_cancel        (ctrl_xx_ex2_cancel),
        .ctrl_xx_ex4_stall         (ctrl_xx_ex4_stall),
        .fmau_fpu_ex1_cmplt        (fmau_fpu_ex1_cmplt),
        .fmau_fpu_ex1_special_sel  (fmau_fpu_ex1_special_sel),
        .fmau_fpu_ex1_special_sign (fmau_fpu_ex1_special_sign),
        .fmau_fpu_ex1_fflags       (fmau_fpu_ex1_fflags),
        .idu_fpu_ex1_srcf0         (idu_fpu_ex1_srcf0),
        .idu_fpu_ex1_srcf1         (idu_fpu_ex1_srcf1),
        .dp_xx_ex1_srcf2           (dp_xx_ex1_srcf2),
        .fmau_fpu_ex3_result_vld   (fmau_fpu_ex3_result_vld),
        .fmau_fpu_ex3_result       (fmau_fpu_ex3_result),
        .fmau_fpu_ex3_fflags       (fmau_fpu_ex3_fflags),
        .fmau_fpu_ex4_result       (fmau_fpu_ex4_result),
        .fmau_fpu_ex4_fflags       (fmau_fpu_ex4_fflags),
        .rtu_fpu_wb_ready          (rtu_fpu_wb_ready),
        .cp0_fpu_fflags_clr        (cp0_fpu_fflags_clr),
        .fmau_wb_stall             (fmau_wb_stall),
        .fpu_rtu_wb_vld            (fpu_rtu_wb_vld),
        .fpu_rtu_wb_reg            (fpu_rtu_wb_reg),
        .fpu_rtu_wb_data           (fpu_rtu_wb_data),
        .fpu_cp0_fflags            (fpu_cp0_fflags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // IEEE-754 single special results, lowest select bit first.
    function automatic logic [31:0] ref_special(input logic [7:0] sel, input logic [3:0] sg,
                                                input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c);
        int k = -1;
        for (int i = 0; i < 8; i++) if (sel[i] && k < 0) k = i;
        case (k)
            0:       return 32'h7FC00000;
            1:       return sg[0] ? 32'hFF800000 : 32'h7F800000;
            2:       return sg[1] ? 32'h80000000 : 32'h00000000;
            3:       return 32'h7F7FFFFF | (sg[2] ? 32'h80000000 : 32'h0);
            4:       return a;
            5:       return b;
            6:       return c;
            7:       return a | 32'h00400000;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: DUT state after each edge is compared against the model.
    initial begin
        bit pop;
        exp_t e;
        forever begin
            @(negedge forever_cpuclk);
            if (cpurst) begin
                cnt_m = 0;
                sticky_m = '0;
                continue;
            end
            check("wb_vld", fpu_rtu_wb_vld, cnt_m != 0);
            check("wb_stall", fmau_wb_stall, cnt_m >= 2);
            check("fflags", fpu_cp0_fflags, sticky_m);
            pop = (cnt_m > 0) && rtu_fpu_wb_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got reg %0d, expected no entry", fpu_rtu_wb_reg);
                end else begin
                    e = exp_q.pop_front();
                    $display("pop reg=%0d data=%08h flags=%02h", fpu_rtu_wb_reg, fpu_rtu_wb_data, e.f);
                    check("wb_reg", fpu_rtu_wb_reg, e.r);
                    check("wb_data", fpu_rtu_wb_data, e.d);
                    sticky_m = cp0_fpu_fflags_clr ? e.f : (sticky_m | e.f);
                end
            end else if (cp0_fpu_fflags_clr) begin
                sticky_m = '0;
            end
            cnt_m = cnt_m + n_push_now - (pop ? 1 : 0);
        end
    end

    initial begin
        rtu_fpu_wb_ready = 1'b0;
        forever begin
            @(posedge forever_cpuclk);
            #2;
            case (ready_mode)
                0:       rtu_fpu_wb_ready = 1'b0;
                1:       rtu_fpu_wb_ready = 1'b1;
                default: rtu_fpu_wb_ready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic idle_inputs();
        idu_fpu_ex1_dst_reg = '0;
        ctrl_wb_ex1_pipe_down = 1'b0;
        ctrl_wb_ex2_pipe_down = 1'b0;
        ctrl_wb_ex3_pipe_down = 1'b0;
        rtu_xx_ex1_cancel = 1'b0;
        ctrl_xx_ex2_cancel = 1'b0;
        ctrl_xx_ex4_stall = 1'b1;
        fmau_fpu_ex1_cmplt = 1'b0;
        fmau_fpu_ex1_special_sel = '0;
        fmau_fpu_ex1_special_sign = '0;
        fmau_fpu_ex1_fflags = '0;
        idu_fpu_ex1_srcf0 = '0;
        idu_fpu_ex1_srcf1 = '0;
        dp_xx_ex1_srcf2 = '0;
        fmau_fpu_ex3_result_vld = 1'b0;
        fmau_fpu_ex3_result = '0;
        fmau_fpu_ex3_fflags = '0;
        fmau_fpu_ex4_result = '0;
        fmau_fpu_ex4_fflags = '0;
        cp0_fpu_fflags_clr = rand_clr && ($urandom_range(0, 19) == 0);
    endtask

    task automatic next_cycle();
        @(posedge forever_cpuclk);
        #1;
        idle_inputs();
        n_push_now = 0;
    endtask

    task automatic exp_push(input logic [4:0] r, input logic [31:0] d, input logic [4:0] f);
        exp_t e;
        e.r = r;
        e.d = d;
        e.f = f;
        exp_q.push_back(e);
        n_push_now++;
    endtask

    task automatic wait_room();
        int n = 0;
        while (cnt_m >= 2) begin
            next_cycle();
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL wait_room: buffer count %0d, expected below 2 within 500 cycles", cnt_m);
                return;
            end
        end
    endtask

    task automatic issue_special(input logic [4:0] dst, input logic [7:0] sel, input logic [3:0] sg,
                                 input logic [4:0] fl, input bit cancel);
        logic [31:0] a, b, c;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        ctrl_wb_ex1_pipe_down = 1'b1;
        fmau_fpu_ex1_cmplt = 1'b1;
        rtu_xx_ex1_cancel = cancel;
        idu_fpu_ex1_dst_reg = dst;
        fmau_fpu_ex1_special_sel = sel;
        fmau_fpu_ex1_special_sign = sg;
        fmau_fpu_ex1_fflags = fl;
        idu_fpu_ex1_srcf0 = a;
        idu_fpu_ex1_srcf1 = b;
        dp_xx_ex1_srcf2 = c;
        if (!cancel && cnt_m < 2) exp_push(dst, ref_special(sel, sg, a, b, c), fl);
    endtask

    task automatic rand_instr();
        int kind = $urandom_range(0, 2);
        logic [4:0] dst = 5'($urandom);
        logic [31:0] res = $urandom;
        logic [4:0] fl = 5'($urandom);
        logic [7:0] sel;
        int n;
        next_cycle();
        if (kind == 0) begin
            case ($urandom_range(0, 2))
                0:       sel = 8'h00;
                1:       sel = 8'h01 << $urandom_range(0, 7);
                default: sel = 8'($urandom);
            endcase
            wait_room();
            issue_special(dst, sel, 4'($urandom), fl, $urandom_range(0, 7) == 0);
            return;
        end
        ctrl_wb_ex1_pipe_down = 1'b1;
        idu_fpu_ex1_dst_reg = dst;
        rtu_xx_ex1_cancel = ($urandom_range(0, 9) == 0);
        if (rtu_xx_ex1_cancel) return;
        next_cycle();
        ctrl_wb_ex2_pipe_down = 1'b1;
        ctrl_xx_ex2_cancel = ($urandom_range(0, 7) == 0);
        if (ctrl_xx_ex2_cancel) return;
        next_cycle();
        if (kind == 1) begin
            wait_room();
            ctrl_wb_ex3_pipe_down = 1'b1;
            fmau_fpu_ex3_result_vld = 1'b1;
            fmau_fpu_ex3_result = res;
            fmau_fpu_ex3_fflags = fl;
            if (cnt_m < 2) exp_push(dst, res, fl);
            return;
        end
        ctrl_wb_ex3_pipe_down = 1'b1;
        for (n = 0; n < 300; n++) begin
            next_cycle();
            fmau_fpu_ex4_result = res;
            fmau_fpu_ex4_fflags = fl;
            ctrl_xx_ex4_stall = ($urandom_range(0, 2) == 0);
            if (!ctrl_xx_ex4_stall && cnt_m < 2) begin
                exp_push(dst, res, fl);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL mac_ex4: EX4 still pending after 300 cycles, expected a push");
    endtask

    initial begin
        int n;
        cpurst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge forever_cpuclk);
        #1;
        cpurst = 1'b0;
        ready_mode = 1;
        @(negedge forever_cpuclk);
        check("rst_reg", fpu_rtu_wb_reg, 5'd0);
        check("rst_data", fpu_rtu_wb_data, 32'd0);

        // MAC through EX1..EX4 with no early result.
        next_cycle(); ctrl_wb_ex1_pipe_down = 1'b1; idu_fpu_ex1_dst_reg = 5'd3;
        next_cycle(); ctrl_wb_ex2_pipe_down = 1'b1;
        next_cycle(); ctrl_wb_ex3_pipe_down = 1'b1;
        next_cycle(); ctrl_xx_ex4_stall = 1'b0;
        fmau_fpu_ex4_result = 32'h3F800000; fmau_fpu_ex4_fflags = 5'h01;
        exp_push(5'd3, 32'h3F800000, 5'h01);
        repeat (3) next_cycle();

        // EX1 special: -infinity.
        issue_special(5'd7, 8'h02, 4'h1, 5'h04, 1'b0);
        check("special_ref", ref_special(8'h02, 4'h1, 32'h0, 32'h0, 32'h0), 32'hFF800000);
        repeat (3) next_cycle();

        // Three completions in one cycle with the write port blocked.
        ready_mode = 0;
        next_cycle(); ctrl_wb_ex1_pipe_down = 1'b1; idu_fpu_ex1_dst_reg = 5'd1;
        next_cycle(); ctrl_wb_ex2_pipe_down = 1'b1;
        ctrl_wb_ex1_pipe_down = 1'b1; idu_fpu_ex1_dst_reg = 5'd2;
        next_cycle(); ctrl_wb_ex3_pipe_down = 1'b1; ctrl_wb_ex2_pipe_down = 1'b1;
        next_cycle();
        ctrl_xx_ex4_stall = 1'b0;
        fmau_fpu_ex4_result = 32'h11111111; fmau_fpu_ex4_fflags = 5'h02;
        exp_push(5'd1, 32'h11111111, 5'h02);
        ctrl_wb_ex3_pipe_down = 1'b1; fmau_fpu_ex3_result_vld = 1'b1;
        fmau_fpu_ex3_result = 32'h22222222; fmau_fpu_ex3_fflags = 5'h08;
        exp_push(5'd2, 32'h22222222, 5'h08);
        issue_special(5'd4, 8'h01, 4'h0, 5'h00, 1'b0);
        repeat (3) next_cycle();
        ready_mode = 1;
        repeat (5) next_cycle();

        // Cancels: EX2 kill of reg 9, and EX1 kill of a special completion.
        next_cycle(); ctrl_wb_ex1_pipe_down = 1'b1; idu_fpu_ex1_dst_reg = 5'd9;
        next_cycle(); ctrl_wb_ex2_pipe_down = 1'b1; ctrl_xx_ex2_cancel = 1'b1;
        next_cycle(); issue_special(5'd10, 8'h10, 4'h0, 5'h1F, 1'b1);
        repeat (3) next_cycle();

        // Clear coinciding with a pop keeps only the popped flags.
        next_cycle(); cp0_fpu_fflags_clr = 1'b1;
        next_cycle(); issue_special(5'd5, 8'h04, 4'h2, 5'h03, 1'b0);
        next_cycle();
        next_cycle(); issue_special(5'd6, 8'h08, 4'h4, 5'h10, 1'b0);
        next_cycle(); cp0_fpu_fflags_clr = 1'b1;
        repeat (2) next_cycle();

        // Reset with two entries queued.
        ready_mode = 0;
        next_cycle(); issue_special(5'd12, 8'h80, 4'h0, 5'h01, 1'b0);
        next_cycle(); issue_special(5'd13, 8'h40, 4'h0, 5'h02, 1'b0);
        repeat (2) next_cycle();
        cpurst = 1'b1;
        exp_q.delete();
        next_cycle();
        cpurst = 1'b0;
        @(negedge forever_cpuclk);
        check("rst2_reg", fpu_rtu_wb_reg, 5'd0);
        check("rst2_data", fpu_rtu_wb_data, 32'd0);

        // Randomized traffic with random back-pressure and flag clears.
        ready_mode = 2;
        rand_clr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_instr();
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
        rand_clr = 1'b0;

        ready_mode = 1;
        n = 0;
        while (cnt_m > 0 && n < 100) begin
            next_cycle();
            n++;
        end
        next_cycle();
        @(negedge forever_cpuclk);
        check("drain_queue", exp_q.size(), 0);
        check("drain_vld", fpu_rtu_wb_vld, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
